// File: rtl/hazard_scoreboard_if.sv
// Decode/write-back side bundle of the hazard scoreboard: issue handshake, releases, lookups, status.
// Names keep the scoreboard's direction suffix so both ends read the same way.
interface hazard_scoreboard_if #(
  parameter int RF_ADDR_WIDTH = 5
);
  logic                     flush_i;
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic                     issue_gpr_we_i;
  logic [RF_ADDR_WIDTH-1:0] issue_rd_i;
  logic                     issue_csr_we_i;
  logic                     wb_gpr_valid_i;
  logic [RF_ADDR_WIDTH-1:0] wb_rd_i;
  logic                     wb_csr_valid_i;
  logic [RF_ADDR_WIDTH-1:0] rs1_i;
  logic                     rs1_dirty_o;
  logic [RF_ADDR_WIDTH-1:0] rs2_i;
  logic                     rs2_dirty_o;
  logic                     csr_dirty_o;
  logic                     underflow_o;

  modport master (
    output flush_i, issue_valid_i, issue_gpr_we_i, issue_rd_i, issue_csr_we_i,
    output wb_gpr_valid_i, wb_rd_i, wb_csr_valid_i, rs1_i, rs2_i,
    input  issue_ready_o, rs1_dirty_o, rs2_dirty_o, csr_dirty_o, underflow_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_gpr_we_i, issue_rd_i, issue_csr_we_i,
    input  wb_gpr_valid_i, wb_rd_i, wb_csr_valid_i, rs1_i, rs2_i,
    output issue_ready_o, rs1_dirty_o, rs2_dirty_o, csr_dirty_o, underflow_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-GPR and CSR pending-write counters; issue sets dirty at t+1, release clears it at t+1.
// Backpressure: issue_ready_o drops combinationally when the targeted counter is at MAX_PENDING.
module hazard_scoreboard #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MAX_PENDING   = 3
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  hazard_scoreboard_if.slave sb
);

  localparam int               CNT_W    = $clog2(MAX_PENDING + 1);
  localparam int               NUM_REGS = 1 << RF_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_PENDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Entry 0 exists only to keep indexing simple; it is held at zero and masked on lookup.
  logic [CNT_W-1:0]    gpr_cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    gpr_cnt_d [NUM_REGS];
  logic [CNT_W-1:0]    csr_cnt_q;
  logic [CNT_W-1:0]    csr_cnt_d;
  logic                underflow_q;
  logic                underflow_d;

  logic                gpr_full;
  logic                csr_full;
  logic                issue_accept;
  logic [NUM_REGS-1:0] gpr_inc;
  logic [NUM_REGS-1:0] gpr_dec;
  logic                csr_inc;
  logic                csr_dec;

  assign gpr_full = sb.issue_gpr_we_i && (sb.issue_rd_i != '0)
                 && (gpr_cnt_q[sb.issue_rd_i] == CNT_MAX);
  assign csr_full = sb.issue_csr_we_i && (csr_cnt_q == CNT_MAX);

  assign sb.issue_ready_o = !(gpr_full || csr_full);
  assign issue_accept     = sb.issue_valid_i && sb.issue_ready_o;

  assign sb.rs1_dirty_o = (sb.rs1_i != '0) && (gpr_cnt_q[sb.rs1_i] != '0);
  assign sb.rs2_dirty_o = (sb.rs2_i != '0) && (gpr_cnt_q[sb.rs2_i] != '0);
  assign sb.csr_dirty_o = (csr_cnt_q != '0);
  assign sb.underflow_o = underflow_q;

  always_comb begin
    gpr_inc = '0;
    gpr_dec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      gpr_inc[i] = issue_accept && sb.issue_gpr_we_i
                && (sb.issue_rd_i == RF_ADDR_WIDTH'(i));
      gpr_dec[i] = sb.wb_gpr_valid_i && (sb.wb_rd_i == RF_ADDR_WIDTH'(i));
    end
    csr_inc = issue_accept && sb.issue_csr_we_i;
    csr_dec = sb.wb_csr_valid_i;
  end

  // Flush wins over issue/release and also masks any release that would otherwise underflow.
  always_comb begin
    gpr_cnt_d   = gpr_cnt_q;
    csr_cnt_d   = csr_cnt_q;
    underflow_d = underflow_q;
    gpr_cnt_d[0] = '0;
    if (sb.flush_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_cnt_d[i] = '0;
      end
      csr_cnt_d = '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (gpr_inc[i] && !gpr_dec[i]) begin
          gpr_cnt_d[i] = gpr_cnt_q[i] + CNT_ONE;
        end else if (gpr_dec[i] && !gpr_inc[i]) begin
          if (gpr_cnt_q[i] == '0) begin
            underflow_d = 1'b1;
          end else begin
            gpr_cnt_d[i] = gpr_cnt_q[i] - CNT_ONE;
          end
        end
      end
      if (csr_inc && !csr_dec) begin
        csr_cnt_d = csr_cnt_q + CNT_ONE;
      end else if (csr_dec && !csr_inc) begin
        if (csr_cnt_q == '0) begin
          underflow_d = 1'b1;
        end else begin
          csr_cnt_d = csr_cnt_q - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_cnt_q[i] <= '0;
      end
      csr_cnt_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      gpr_cnt_q   <= gpr_cnt_d;
      csr_cnt_q   <= csr_cnt_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; outputs packed as {ready, rs1_dirty, rs2_dirty, csr_dirty, underflow}.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] exp_q [$];
  string      tag_q [$];

  hazard_scoreboard_if #(.RF_ADDR_WIDTH(5)) sb_if ();

  hazard_scoreboard #(.RF_ADDR_WIDTH(5), .MAX_PENDING(3)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .sb     (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic drv(input logic iv, input logic gw, input logic [4:0] rd, input logic cw,
                     input logic wg, input logic [4:0] wrd, input logic wc,
                     input logic [4:0] r1, input logic [4:0] r2, input logic fl);
    sb_if.issue_valid_i  = iv;
    sb_if.issue_gpr_we_i = gw;
    sb_if.issue_rd_i     = rd;
    sb_if.issue_csr_we_i = cw;
    sb_if.wb_gpr_valid_i = wg;
    sb_if.wb_rd_i        = wrd;
    sb_if.wb_csr_valid_i = wc;
    sb_if.rs1_i          = r1;
    sb_if.rs2_i          = r2;
    sb_if.flush_i        = fl;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare every queued expectation mid-cycle, then advance one clock.
  task automatic tick();
    logic [4:0] obs;
    logic [4:0] e;
    string      t;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {sb_if.issue_ready_o, sb_if.rs1_dirty_o, sb_if.rs2_dirty_o,
             sb_if.csr_dirty_o, sb_if.underflow_o};
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset state
    expect_out("reset_idle", 5'b10000);                          tick();

    // Issue rd=5, dirty one cycle later, release at t3 clears at t4
    drv(1, 1, 5, 0, 0, 0, 0, 5, 0, 0); expect_out("rd5_t0", 5'b10000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 5, 0, 0); expect_out("rd5_t1", 5'b11000); tick();
    expect_out("rd5_t2", 5'b11000);                              tick();
    drv(0, 0, 0, 0, 1, 5, 0, 5, 0, 0); expect_out("rd5_t3_wb", 5'b11000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 5, 0, 0); expect_out("rd5_t4", 5'b10000); tick();

    // Saturate rd=7 at MAX_PENDING
    drv(1, 1, 7, 0, 0, 0, 0, 0, 7, 0); expect_out("rd7_iss1", 5'b10000); tick();
    expect_out("rd7_iss2", 5'b10100);                            tick();
    expect_out("rd7_iss3", 5'b10100);                            tick();
    expect_out("rd7_full", 5'b00100);                            tick();
    drv(1, 1, 8, 0, 0, 0, 0, 8, 7, 0); expect_out("rd8_ready", 5'b10100); tick();
    drv(0, 1, 7, 0, 1, 7, 0, 8, 7, 0); expect_out("rd7_full_wb", 5'b01100); tick();
    drv(0, 1, 7, 0, 0, 0, 0, 8, 7, 0); expect_out("rd7_after_wb", 5'b11100); tick();
    drv(0, 0, 0, 0, 1, 7, 0, 0, 0, 0); expect_out("rd7_rel_a", 5'b10000); tick();
    drv(0, 0, 0, 0, 1, 7, 0, 0, 0, 0); expect_out("rd7_rel_b", 5'b10000); tick();
    drv(0, 0, 0, 0, 1, 8, 0, 0, 0, 0); expect_out("rd8_rel", 5'b10000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 7, 8, 0); expect_out("rd7_rd8_clean", 5'b10000); tick();

    // Simultaneous issue+release on rd=9 with count 1
    drv(1, 1, 9, 0, 0, 0, 0, 9, 0, 0); expect_out("rd9_iss", 5'b10000); tick();
    drv(1, 1, 9, 0, 1, 9, 0, 9, 0, 0); expect_out("rd9_iss_wb", 5'b11000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9, 0, 0); expect_out("rd9_held", 5'b11000); tick();
    drv(0, 0, 0, 0, 1, 9, 0, 9, 0, 0); expect_out("rd9_rel", 5'b11000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 9, 0, 0); expect_out("rd9_clean", 5'b10000); tick();

    // x0 is never tracked
    drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("x0_iss", 5'b10000); tick();
    drv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); expect_out("x0_wb", 5'b10000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("x0_no_uf", 5'b10000); tick();

    // CSR pending, then flush overriding a same-cycle issue
    drv(1, 0, 0, 1, 0, 0, 0, 3, 0, 0); expect_out("csr_iss1", 5'b10000); tick();
    expect_out("csr_iss2", 5'b10010);                            tick();
    drv(1, 1, 3, 0, 0, 0, 0, 3, 0, 1); expect_out("flush_iss3", 5'b10010); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 3, 0, 0); expect_out("after_flush", 5'b10000); tick();

    // CSR saturation; ready ignores a same-cycle release
    drv(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("csr_s1", 5'b10000); tick();
    expect_out("csr_s2", 5'b10010);                              tick();
    expect_out("csr_s3", 5'b10010);                              tick();
    drv(1, 0, 0, 1, 0, 0, 1, 0, 0, 0); expect_out("csr_full_wb", 5'b00010); tick();
    drv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); expect_out("csr_two_left", 5'b10010); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_out("csr_flush", 5'b10010); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("csr_flushed", 5'b10000); tick();

    // Underflow on rd=12: sticky, counter stays at 0, survives flush
    drv(0, 0, 0, 0, 1, 12, 0, 12, 0, 0); expect_out("uf_wb", 5'b10000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 12, 0, 0);  expect_out("uf_set", 5'b10001); tick();
    drv(1, 1, 12, 0, 0, 0, 0, 12, 0, 0); expect_out("uf_iss12", 5'b10001); tick();
    drv(0, 0, 0, 0, 1, 12, 0, 12, 0, 0); expect_out("uf_cnt_one", 5'b11001); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 12, 0, 1);  expect_out("uf_flush", 5'b10001); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 12, 0, 0);  expect_out("uf_sticky", 5'b10001); tick();
    rstn = 1'b0;                                                 tick();
    expect_out("uf_reset", 5'b10000);
    rstn = 1'b1;                                                 tick();

    // Issue+release on an empty counter is not an underflow
    drv(1, 1, 13, 0, 1, 13, 0, 13, 0, 0); expect_out("net0_cycle", 5'b10000); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 13, 0, 0);   expect_out("net0_after", 5'b10000); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
